// File: rtl/adam_periph_uart_rx_if.sv
// ----------------------------------------------------------------------------
// adam_periph_uart_rx_if
// Valid/ready stream carrying received UART words from the receiver to the
// RX FIFO/register bank.
//   m_data  : received word, zero-extended (master -> slave)
//   m_valid : word present, held until accepted (master -> slave)
//   m_ready : consumer can take the word (slave -> master)
// ----------------------------------------------------------------------------
interface adam_periph_uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/adam_periph_uart_rx.sv
// ----------------------------------------------------------------------------
// adam_periph_uart_rx
// UART receive stage. Synchronizes the rx pin, reassembles frames
// (start, 1..15 data bits LSB first, optional parity, 1..2 stop bits) and
// pushes each data word onto a valid/ready stream. Configuration may only
// change while pause_req && pause_ack.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   pause_req/ack   : pause handshake; ack rises only from IDLE
//   parity_select   : 0 = even, 1 = odd
//   parity_control  : 1 = parity bit present
//   data_length     : data bits per frame (1..15)
//   stop_bits       : 0 = one stop bit, 1 = two
//   baud_rate       : bit period minus one, in clk cycles (>= 3)
//   stream          : master side of the received-word stream
//   rx              : asynchronous serial input, idle high
//   parity_err, frame_err, overrun_err : single-cycle error pulses
//   break_det       : single-cycle break pulse (ADAM_PERIPH_UART_RX_BREAK_EN only)
//
// Optional feature macro: ADAM_PERIPH_UART_RX_BREAK_EN
//   Defined   : an all-zero frame through the first stop bit is reported on
//               break_det, no word is pushed and the receiver waits for the
//               line to return high.
//   Undefined : the same frame is an ordinary framing error and the all-zero
//               word is delivered.
// ----------------------------------------------------------------------------
module adam_periph_uart_rx #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  parity_select,
  input  logic                  parity_control,
  input  logic [3:0]            data_length,
  input  logic                  stop_bits,
  input  logic [DATA_WIDTH-1:0] baud_rate,
  adam_periph_uart_rx_if.master stream,
  input  logic                  rx,
  output logic                  parity_err,
  output logic                  frame_err,
`ifdef ADAM_PERIPH_UART_RX_BREAK_EN
  output logic                  overrun_err,
  output logic                  break_det
`else
  output logic                  overrun_err
`endif
);

  localparam int unsigned SHIFT_W = 15;
  localparam int unsigned IDX_W   = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef ADAM_PERIPH_UART_RX_BREAK_EN
  localparam logic [2:0] ST_BREAK  = 3'd6;
`endif

  // Synchronizer and edge-detect history
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // FSM and datapath state
  logic [2:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] cnt_q,       cnt_d;
  logic [IDX_W-1:0]      bit_idx_q,   bit_idx_d;
  logic                  stop_idx_q,  stop_idx_d;
  logic [SHIFT_W-1:0]    shift_q,     shift_d;
  logic                  xor_q,       xor_d;
  logic                  ones_q,      ones_d;
  logic                  perr_q,      perr_d;
  logic                  ferr_q,      ferr_d;

  // Registered outputs
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  valid_q,     valid_d;
  logic                  ack_q,       ack_d;
  logic                  perr_p_q,    perr_p_d;
  logic                  ferr_p_q,    ferr_p_d;
  logic                  ovr_p_q,     ovr_p_d;
  logic                  brk_p_q,     brk_p_d;

  logic fall_c;
  logic bit_tick_c;
  logic half_tick_c;
  logic last_data_c;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_c      = rx_prev_q & ~rx_s_q;
  assign bit_tick_c  = (cnt_q == baud_rate);
  assign half_tick_c = (cnt_q == (baud_rate >> 1));
  assign last_data_c = ((5'(bit_idx_q) + 5'd1) >= 5'(data_length));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      xor_q      <= 1'b0;
      ones_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b1;
      perr_p_q   <= 1'b0;
      ferr_p_q   <= 1'b0;
      ovr_p_q    <= 1'b0;
      brk_p_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      ones_q     <= ones_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      perr_p_q   <= perr_p_d;
      ferr_p_q   <= ferr_p_d;
      ovr_p_q    <= ovr_p_d;
      brk_p_q    <= brk_p_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    ones_d     = ones_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q & ~stream.m_ready;
    ack_d      = ack_q;
    perr_p_d   = 1'b0;
    ferr_p_d   = 1'b0;
    ovr_p_d    = 1'b0;
    brk_p_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pause_req) begin
          ack_d = 1'b1;
        end else begin
          ack_d = 1'b0;
          if (fall_c) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
      end

      ST_START: begin
        if (half_tick_c) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            // Restarting here puts every later sample at mid-bit
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
            shift_d   = '0;
            xor_d     = 1'b0;
            ones_d    = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end

      ST_DATA: begin
        if (bit_tick_c) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          xor_d            = xor_q ^ rx_s_q;
          ones_d           = ones_q | rx_s_q;
          if (last_data_c) begin
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = parity_control ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end

      ST_PARITY: begin
        if (bit_tick_c) begin
          cnt_d      = '0;
          perr_d     = rx_s_q ^ xor_q ^ parity_select;
          ones_d     = ones_q | rx_s_q;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end

      ST_STOP: begin
        if (bit_tick_c) begin
          cnt_d = '0;
`ifdef ADAM_PERIPH_UART_RX_BREAK_EN
          if (!stop_idx_q && !rx_s_q && !ones_q) begin
            brk_p_d = 1'b1;
            state_d = ST_BREAK;
          end else
`endif
          begin
            if (!rx_s_q) begin
              ferr_d = 1'b1;
            end
            // Leave at mid-bit of the last stop bit
            if (stop_idx_q == stop_bits) begin
              state_d = ST_DONE;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end

      ST_DONE: begin
        // A still-pending word wins; the new one is dropped
        if (valid_q) begin
          ovr_p_d = 1'b1;
        end else begin
          data_d  = DATA_WIDTH'(shift_q);
          valid_d = 1'b1;
        end
        perr_p_d = perr_q;
        ferr_p_d = ferr_q;
        state_d  = ST_IDLE;
      end

`ifdef ADAM_PERIPH_UART_RX_BREAK_EN
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stream.m_data  = data_q;
  assign stream.m_valid = valid_q;
  assign pause_ack      = ack_q;
  assign parity_err     = perr_p_q;
  assign frame_err      = ferr_p_q;
  assign overrun_err    = ovr_p_q;
`ifdef ADAM_PERIPH_UART_RX_BREAK_EN
  assign break_det      = brk_p_q;
`else
  // Break detection is compiled out; the pulse register stays at reset
  logic unused_brk_c;
  assign unused_brk_c = brk_p_q;
`endif

endmodule
